// File: rtl/bram_arbiter_if.sv
// Requester and BRAM port-B signal bundle for bram_arbiter.
// slave = arbiter view, master = requesters plus BRAM model view.
interface bram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              gnt_id;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, mem_addr, mem_we, mem_wdata, busy, gnt_id
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, mem_addr, mem_we, mem_wdata, busy, gnt_id
  );
endinterface

// File: rtl/bram_arbiter.sv
// Two-requester arbiter for the shared BRAM port B: IDLE -> ACCESS -> RESP per access.
// Define BRAM_ARB_ROUND_ROBIN_EN for round-robin; otherwise requester 0 has fixed priority.
module bram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  bram_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic              mem_we_reg, mem_we_next;
  logic              gnt_id_reg, gnt_id_next;
  logic              busy_reg, busy_next;
  logic              any_req;
  logic              winner;
  logic              resp_active;

  always_comb begin
    any_req = bus.req0 | bus.req1;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    // On a tie the requester that did not own the last access wins.
    if (bus.req0 && bus.req1) begin
      winner = ~gnt_id_reg;
    end else begin
      winner = bus.req1;
    end
`else
    winner = ~bus.req0;
`endif
  end

  always_comb begin
    state_next     = state_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_we_next    = mem_we_reg;
    gnt_id_next    = gnt_id_reg;
    busy_next      = busy_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next     = ACCESS;
          mem_addr_next  = winner ? bus.addr1  : bus.addr0;
          mem_wdata_next = winner ? bus.wdata1 : bus.wdata0;
          mem_we_next    = winner ? bus.we1    : bus.we0;
          gnt_id_next    = winner;
          busy_next      = 1'b1;
        end
      end
      ACCESS: begin
        // The BRAM samples the port at this edge; keep addr/wdata, drop the strobe.
        state_next  = RESP;
        mem_we_next = 1'b0;
      end
      RESP: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
      default: begin
        state_next  = IDLE;
        mem_we_next = 1'b0;
        busy_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_we_reg    <= 1'b0;
      gnt_id_reg    <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_we_reg    <= mem_we_next;
      gnt_id_reg    <= gnt_id_next;
      busy_reg      <= busy_next;
    end
  end

  // Response is decoded from registered state; read data passes straight from the BRAM.
  assign resp_active = (state_reg == RESP);
  assign bus.ack0    = resp_active & ~gnt_id_reg;
  assign bus.ack1    = resp_active &  gnt_id_reg;
  assign bus.rdata0  = bus.ack0 ? bus.mem_rdata : '0;
  assign bus.rdata1  = bus.ack1 ? bus.mem_rdata : '0;

  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.busy      = busy_reg;
  assign bus.gnt_id    = gnt_id_reg;
endmodule
